// File: rtl/proc_mem_arb_pkg.sv
// Shared types and constants for the processor/memory arbiter and its tag queue.
// Tags record which requester owns each outstanding memory transaction.
package proc_mem_arb_pkg;

   typedef logic tag_t;

   localparam tag_t TAG_IMEM  = 1'b0;
   localparam tag_t TAG_DMEM  = 1'b1;
   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/arb_tag_queue.sv
// In-order owner-tag FIFO, DEPTH entries (power of two); push/pop take effect at the clock edge.
// Head is combinational from storage; a push while full or a pop while empty is ignored.
module arb_tag_queue
   import proc_mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  tag_t i_tag,
   input  logic i_pop,
   output tag_t o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   tag_t [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_tag;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/proc_mem_arb.sv
// Imem/dmem arbiter onto one memory port: dmem priority with imem starvation guard, 0-cycle req/resp.
// Optional perf counters built only when PROC_MEM_ARB_PERF_EN is defined; otherwise perf_* read 0.
module proc_mem_arb
   import proc_mem_arb_pkg::*;
#(
   parameter int MAX_OUTS     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   output logic        imemreq_rdy,
   input  logic [31:0] imemreq_addr,
   output logic        imemresp_val,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   output logic        dmemreq_rdy,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic        dmemresp_val,
   output logic [31:0] dmemresp_rdata,
   output logic        memreq_val,
   input  logic        memreq_rdy,
   output logic        memreq_type,
   output logic [31:0] memreq_addr,
   output logic [31:0] memreq_wdata,
   input  logic        memresp_val,
   input  logic [31:0] memresp_data,
   output logic        err,
   output logic [31:0] perf_igrant,
   output logic [31:0] perf_dgrant,
   output logic [31:0] perf_conflict
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0] r_starve;
   logic       r_err;
   logic       w_full;
   logic       w_empty;
   tag_t       w_head;
   logic       w_starved;
   logic       w_dwin;
   logic       w_iwin;
   logic       w_iacc;
   logic       w_dacc;
   logic       w_pop;

   assign w_starved = (r_starve == STARVE_MAX) & imemreq_val;
   assign w_dwin    = dmemreq_val & ~w_starved;
   assign w_iwin    = imemreq_val & ~w_dwin;

   assign memreq_val  = (w_dwin | w_iwin) & ~w_full;
   assign imemreq_rdy = w_iwin & memreq_rdy & ~w_full;
   assign dmemreq_rdy = w_dwin & memreq_rdy & ~w_full;
   assign w_iacc      = imemreq_val & imemreq_rdy;
   assign w_dacc      = dmemreq_val & dmemreq_rdy;

   always_comb begin
      memreq_type  = REQ_READ;
      memreq_addr  = '0;
      memreq_wdata = '0;
      if (w_dwin) begin
         memreq_type  = dmemreq_type;
         memreq_addr  = dmemreq_addr;
         memreq_wdata = dmemreq_wdata;
      end else if (w_iwin) begin
         memreq_addr  = imemreq_addr;
      end
   end

   arb_tag_queue #(.DEPTH(MAX_OUTS)) u_tagq (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_iacc | w_dacc),
      .i_tag   (w_dacc ? TAG_DMEM : TAG_IMEM),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A response with nothing outstanding is dropped rather than misrouted.
   assign w_pop          = memresp_val & ~w_empty;
   assign imemresp_val   = w_pop & (w_head == TAG_IMEM);
   assign dmemresp_val   = w_pop & (w_head == TAG_DMEM);
   assign imemresp_data  = memresp_data;
   assign dmemresp_rdata = memresp_data;
   assign err            = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= '0;
         r_err    <= 1'b0;
      end else begin
         if (!imemreq_val || w_iacc)
            r_starve <= '0;
         else if (r_starve != STARVE_MAX)
            r_starve <= r_starve + 4'd1;
         if (memresp_val && w_empty)
            r_err <= 1'b1;
      end
   end

`ifdef PROC_MEM_ARB_PERF_EN
   logic [31:0] r_perf_i;
   logic [31:0] r_perf_d;
   logic [31:0] r_perf_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_i <= '0;
         r_perf_d <= '0;
         r_perf_c <= '0;
      end else begin
         if (w_iacc)
            r_perf_i <= r_perf_i + 32'd1;
         if (w_dacc)
            r_perf_d <= r_perf_d + 32'd1;
         if (imemreq_val && dmemreq_val)
            r_perf_c <= r_perf_c + 32'd1;
      end
   end

   assign perf_igrant   = r_perf_i;
   assign perf_dgrant   = r_perf_d;
   assign perf_conflict = r_perf_c;
`else
   assign perf_igrant   = '0;
   assign perf_dgrant   = '0;
   assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed bench for proc_mem_arb with MAX_OUTS=2, STARVE_LIMIT=4.
module tb_proc_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemreq_val;
   logic        imemreq_rdy;
   logic [31:0] imemreq_addr;
   logic        imemresp_val;
   logic [31:0] imemresp_data;
   logic        dmemreq_val;
   logic        dmemreq_rdy;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic        dmemresp_val;
   logic [31:0] dmemresp_rdata;
   logic        memreq_val;
   logic        memreq_rdy;
   logic        memreq_type;
   logic [31:0] memreq_addr;
   logic [31:0] memreq_wdata;
   logic        memresp_val;
   logic [31:0] memresp_data;
   logic        err;
   logic [31:0] perf_igrant;
   logic [31:0] perf_dgrant;
   logic [31:0] perf_conflict;

   int errors = 0;
   int checks = 0;

   proc_mem_arb #(.MAX_OUTS(2), .STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .imemreq_val    (imemreq_val),
      .imemreq_rdy    (imemreq_rdy),
      .imemreq_addr   (imemreq_addr),
      .imemresp_val   (imemresp_val),
      .imemresp_data  (imemresp_data),
      .dmemreq_val    (dmemreq_val),
      .dmemreq_rdy    (dmemreq_rdy),
      .dmemreq_type   (dmemreq_type),
      .dmemreq_addr   (dmemreq_addr),
      .dmemreq_wdata  (dmemreq_wdata),
      .dmemresp_val   (dmemresp_val),
      .dmemresp_rdata (dmemresp_rdata),
      .memreq_val     (memreq_val),
      .memreq_rdy     (memreq_rdy),
      .memreq_type    (memreq_type),
      .memreq_addr    (memreq_addr),
      .memreq_wdata   (memreq_wdata),
      .memresp_val    (memresp_val),
      .memresp_data   (memresp_data),
      .err            (err),
      .perf_igrant    (perf_igrant),
      .perf_dgrant    (perf_dgrant),
      .perf_conflict  (perf_conflict)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; checks happen 1ns later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      imemreq_val   = 1'b0;
      imemreq_addr  = '0;
      dmemreq_val   = 1'b0;
      dmemreq_type  = 1'b0;
      dmemreq_addr  = '0;
      dmemreq_wdata = '0;
      memreq_rdy    = 1'b1;
      memresp_val   = 1'b0;
      memresp_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      #3;
      checks++; if (imemreq_rdy !== 1'b0) begin errors++; $display("FAIL rst_irdy got=%b exp=0", imemreq_rdy); end
      checks++; if (dmemreq_rdy !== 1'b0) begin errors++; $display("FAIL rst_drdy got=%b exp=0", dmemreq_rdy); end
      checks++; if (memreq_val !== 1'b0) begin errors++; $display("FAIL rst_mval got=%b exp=0", memreq_val); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++; if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin errors++; $display("FAIL rst_resp got=%b%b exp=00", imemresp_val, dmemresp_val); end
      #4 rst = 1'b1;
   endtask

   task automatic test_imem_only();
      cyc();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h200;
      #1;
      checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL io_irdy got=%b exp=1", imemreq_rdy); end
      checks++; if (memreq_val !== 1'b1) begin errors++; $display("FAIL io_mval got=%b exp=1", memreq_val); end
      checks++; if (memreq_addr !== 32'h200) begin errors++; $display("FAIL io_addr got=%h exp=00000200", memreq_addr); end
      checks++; if (memreq_type !== 1'b0 || memreq_wdata !== 32'h0) begin errors++; $display("FAIL io_type got=%b/%h exp=0/0", memreq_type, memreq_wdata); end
      cyc();
      idle();
      memresp_val  = 1'b1;
      memresp_data = 32'hDEADBEEF;
      #1;
      checks++; if (imemresp_val !== 1'b1) begin errors++; $display("FAIL io_rval got=%b exp=1", imemresp_val); end
      checks++; if (imemresp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL io_rdata got=%h exp=deadbeef", imemresp_data); end
      checks++; if (dmemresp_val !== 1'b0) begin errors++; $display("FAIL io_dval got=%b exp=0", dmemresp_val); end
      cyc();
      idle();
      #1;
      checks++; if (imemresp_val !== 1'b0 || memreq_val !== 1'b0) begin errors++; $display("FAIL io_idle got=%b%b exp=00", imemresp_val, memreq_val); end
   endtask

   task automatic test_priority();
      cyc();
      imemreq_val   = 1'b1;
      imemreq_addr  = 32'h300;
      dmemreq_val   = 1'b1;
      dmemreq_type  = 1'b1;
      dmemreq_addr  = 32'h1000;
      dmemreq_wdata = 32'h5;
      #1;
      checks++; if (dmemreq_rdy !== 1'b1) begin errors++; $display("FAIL pr_drdy got=%b exp=1", dmemreq_rdy); end
      checks++; if (imemreq_rdy !== 1'b0) begin errors++; $display("FAIL pr_irdy got=%b exp=0", imemreq_rdy); end
      checks++; if (memreq_type !== 1'b1) begin errors++; $display("FAIL pr_type got=%b exp=1", memreq_type); end
      checks++; if (memreq_addr !== 32'h1000) begin errors++; $display("FAIL pr_addr got=%h exp=00001000", memreq_addr); end
      checks++; if (memreq_wdata !== 32'h5) begin errors++; $display("FAIL pr_wdata got=%h exp=00000005", memreq_wdata); end
      cyc();
      idle();
      memresp_val  = 1'b1;
      memresp_data = 32'hA5;
      #1;
      checks++; if (dmemresp_val !== 1'b1 || imemresp_val !== 1'b0) begin errors++; $display("FAIL pr_resp got=%b%b exp=10", dmemresp_val, imemresp_val); end
      checks++; if (dmemresp_rdata !== 32'hA5) begin errors++; $display("FAIL pr_rdata got=%h exp=000000a5", dmemresp_rdata); end
      cyc();
      idle();
   endtask

   task automatic test_starvation();
      logic prev_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         logic exp_i;
         cyc();
         imemreq_val  = 1'b1;
         imemreq_addr = 32'h400;
         dmemreq_val  = 1'b1;
         dmemreq_type = 1'b0;
         dmemreq_addr = 32'h80 + 32'(k);
         memresp_val  = (k > 0);
         memresp_data = 32'(k);
         exp_i = (k == 4);
         #1;
         checks++; if (imemreq_rdy !== exp_i) begin errors++; $display("FAIL st_irdy[%0d] got=%b exp=%b", k, imemreq_rdy, exp_i); end
         checks++; if (dmemreq_rdy !== !exp_i) begin errors++; $display("FAIL st_drdy[%0d] got=%b exp=%b", k, dmemreq_rdy, !exp_i); end
         if (k > 0) begin
            checks++; if (imemresp_val !== prev_i || dmemresp_val !== !prev_i) begin errors++; $display("FAIL st_route[%0d] got=%b%b exp=%b%b", k, imemresp_val, dmemresp_val, prev_i, !prev_i); end
         end
         prev_i = exp_i;
      end
      cyc();
      idle();
      memresp_val = 1'b1;
      #1;
      checks++; if (dmemresp_val !== 1'b1) begin errors++; $display("FAIL st_drain got=%b exp=1", dmemresp_val); end
      cyc();
      idle();
   endtask

   task automatic test_full();
      for (int k = 0; k < 2; k++) begin
         cyc();
         imemreq_val  = 1'b1;
         imemreq_addr = 32'h600 + 32'(4 * k);
         #1;
         checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL fu_acc[%0d] got=%b exp=1", k, imemreq_rdy); end
      end
      cyc();
      #1;
      checks++; if (imemreq_rdy !== 1'b0 || memreq_val !== 1'b0) begin errors++; $display("FAIL fu_block got=%b%b exp=00", imemreq_rdy, memreq_val); end
      cyc();
      memresp_val  = 1'b1;
      memresp_data = 32'h11;
      #1;
      checks++; if (imemreq_rdy !== 1'b0) begin errors++; $display("FAIL fu_poppush got=%b exp=0", imemreq_rdy); end
      checks++; if (imemresp_val !== 1'b1) begin errors++; $display("FAIL fu_pop got=%b exp=1", imemresp_val); end
      cyc();
      memresp_val = 1'b0;
      #1;
      checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL fu_after got=%b exp=1", imemreq_rdy); end
      for (int k = 0; k < 2; k++) begin
         cyc();
         idle();
         memresp_val = 1'b1;
         #1;
         checks++; if (imemresp_val !== 1'b1) begin errors++; $display("FAIL fu_drain[%0d] got=%b exp=1", k, imemresp_val); end
      end
      cyc();
      idle();
   endtask

   task automatic test_interleave();
      cyc();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h700;
      #1;
      checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL il_i0 got=%b exp=1", imemreq_rdy); end
      cyc();
      idle();
      dmemreq_val  = 1'b1;
      dmemreq_addr = 32'h40;
      #1;
      checks++; if (dmemreq_rdy !== 1'b1) begin errors++; $display("FAIL il_d1 got=%b exp=1", dmemreq_rdy); end
      cyc();
      idle();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h704;
      memresp_val  = 1'b1;
      memresp_data = 32'h1;
      #1;
      checks++; if (imemresp_val !== 1'b1 || imemresp_data !== 32'h1 || dmemresp_val !== 1'b0) begin errors++; $display("FAIL il_r1 got=%b%b/%h exp=10/00000001", imemresp_val, dmemresp_val, imemresp_data); end
      cyc();
      memresp_data = 32'h2;
      #1;
      checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL il_i2 got=%b exp=1", imemreq_rdy); end
      checks++; if (dmemresp_val !== 1'b1 || dmemresp_rdata !== 32'h2 || imemresp_val !== 1'b0) begin errors++; $display("FAIL il_r2 got=%b%b/%h exp=01/00000002", imemresp_val, dmemresp_val, dmemresp_rdata); end
      cyc();
      imemreq_val  = 1'b0;
      memresp_data = 32'h3;
      #1;
      checks++; if (imemresp_val !== 1'b1 || imemresp_data !== 32'h3 || dmemresp_val !== 1'b0) begin errors++; $display("FAIL il_r3 got=%b%b/%h exp=10/00000003", imemresp_val, dmemresp_val, imemresp_data); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL il_err got=%b exp=0", err); end
      cyc();
      idle();
   endtask

   task automatic test_reset_mid();
      cyc();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h500;
      #1;
      checks++; if (imemreq_rdy !== 1'b1) begin errors++; $display("FAIL rm_acc got=%b exp=1", imemreq_rdy); end
      cyc();
      idle();
      #1 rst = 1'b0;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_err0 got=%b exp=0", err); end
      rst = 1'b1;
      cyc();
      memresp_val  = 1'b1;
      memresp_data = 32'h77;
      #1;
      checks++; if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin errors++; $display("FAIL rm_drop got=%b%b exp=00", imemresp_val, dmemresp_val); end
      cyc();
      idle();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rm_err1 got=%b exp=1", err); end
      repeat (3) cyc();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rm_hold got=%b exp=1", err); end
      #1 rst = 1'b0;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_clr got=%b exp=0", err); end
      rst = 1'b1;
   endtask

   task automatic test_perf_tied();
`ifndef PROC_MEM_ARB_PERF_EN
      checks++; if (perf_igrant !== 32'h0 || perf_dgrant !== 32'h0 || perf_conflict !== 32'h0) begin errors++; $display("FAIL perf_tie got=%h/%h/%h exp=0/0/0", perf_igrant, perf_dgrant, perf_conflict); end
`endif
   endtask

   initial begin
      test_reset();
      test_imem_only();
      test_priority();
      test_starvation();
      test_full();
      test_interleave();
      test_perf_tied();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/proc_mem_arb.md
Name: proc_mem_arb

Overview:
- Shares one single-ported memory between the pipeline's instruction-fetch port (imem) and its M-stage data port (dmem).
- Arbitrates requests each cycle. Dmem has fixed priority, with a starvation guard for imem.
- Records the owner of every outstanding request in an in-order tag queue and routes each memory response back to its owner.
- Sits between the processor (datapath/control) and the unified memory model.

Parameters:
- MAX_OUTS, 2: outstanding-request capacity (tag queue depth). Power of two, ≥2.
- STARVE_LIMIT, 4: consecutive denied imem cycles before imem wins priority. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low (0 = reset asserted)
- imemreq_val  in  1  fetch request valid
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  32  fetch address
- imemresp_val  out  1  fetch response valid
- imemresp_data  out  32  fetch response data
- dmemreq_val  in  1  data request valid
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0 = read, 1 = write
- dmemreq_addr  in  32  data address
- dmemreq_wdata  in  32  store data
- dmemresp_val  out  1  data response valid
- dmemresp_rdata  out  32  load data
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory can accept
- memreq_type  out  1  0 = read, 1 = write
- memreq_addr  out  32  memory address
- memreq_wdata  out  32  memory store data
- memresp_val  in  1  memory response valid; in order, one per request, including writes
- memresp_data  in  32  memory response data
- err  out  1  sticky: response arrived with empty tag queue
- perf_igrant, perf_dgrant, perf_conflict  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Full = tag queue count == MAX_OUTS.
- Winner (combinational):
  - dmem if dmemreq_val and not (starve == STARVE_LIMIT and imemreq_val).
  - Otherwise imem if imemreq_val.
  - Otherwise none.
- memreq_val = winner exists and !full.
  - memreq_type/addr/wdata are muxed from the winner. Imem requests are type 0 with wdata 0.
  - With no winner, all memreq fields are 0.
- Handshake: xmemreq_rdy = (winner == x) & memreq_rdy & !full.
  - Accept = val & rdy; the request passes combinationally the same cycle (0-cycle request latency).
- A rdy output never depends on that same requester's own val except through the winner select. There is no comb path from memresp_* to any *_rdy.
- Tag queue:
  - Each accept pushes a tag (TAG_IMEM/TAG_DMEM).
  - memresp_val pops the head and drives resp_val of that owner for exactly that cycle.
  - memresp_data is copied unregistered to both resp data outputs (0-cycle response latency).
- Simultaneous push and pop: count unchanged, both take effect.
- Full: no push even if a pop occurs the same cycle, since rdy depends only on registered count.
- Pointers wrap modulo MAX_OUTS.
- memresp_val with empty queue: response dropped, both resp_val stay 0, err set to 1 and held until reset.
- Starvation counter (4b):
  - Cleared when imem is accepted or imemreq_val == 0.
  - Incremented when imemreq_val & !imemreq_rdy, saturating at STARVE_LIMIT.
  - While at limit, imem beats dmem. It clears once imem is accepted.
- Reset (rst == 0, asynchronous): queue empty, count 0, starve 0, err 0, perf counters 0.
  - All registered state clears immediately.
  - Comb outputs follow: rdy/resp_val 0 unless new requests arrive after reset release.
  - Reset mid-operation discards outstanding tags. Late responses then set err.

Optional Feature:
- PROC_MEM_ARB_PERF_EN defined: three 32b wrapping counters.
  - perf_igrant: +1 per imem accept.
  - perf_dgrant: +1 per dmem accept.
  - perf_conflict: +1 per cycle both val are high.
- Undefined: the perf_* ports exist but are tied to 0, and no counter flops are built.

Decomposition:
- Package proc_mem_arb_pkg: tag typedef (1b), TAG_IMEM = 0, TAG_DMEM = 1, REQ_READ = 0, REQ_WRITE = 1.
- One sub-module arb_tag_queue: parameterised DEPTH in-order FIFO with push, pop, head, full, empty, and async active-low reset.

Test Plan:
- Only imemreq_val = 1, addr 0x200, memreq_rdy = 1; next cycle memresp_val = 1, data 0xDEADBEEF -> imemreq_rdy = 1 at cycle 0; imemresp_val = 1 with 0xDEADBEEF at cycle 1; dmemresp_val = 0.
- Both val high, dmem write to 0x1000 with 0x5 -> dmem wins: memreq_type = 1, addr 0x1000, wdata 0x5; imemreq_rdy = 0.
- Both val held high, STARVE_LIMIT = 4, responses returned each cycle -> 4 dmem grants, then 1 imem grant on the 5th cycle, then dmem again.
- MAX_OUTS = 2, memresp held off, two accepts -> third request sees rdy = 0. A pop plus a new request in the same cycle stays blocked; the next cycle the request is accepted.
- Interleaved I, D, I accepted; responses 0x1, 0x2, 0x3 -> routed as imem 0x1, dmem 0x2, imem 0x3.
- One outstanding request, pulse rst low, then memresp_val = 1 -> no resp_val asserted, err = 1 and held until the next reset.
